// File: rtl/track_step_ctrl.sv
// Purpose: closed-loop stepper controller that drives a motor toward an ADC target in three speed zones.
// Latency: a sample is used by the error logic one clk after its strobe; all outputs are registered (one clk).
// Backpressure: none; each strobe overwrites the held sample, and zone changes apply at the next period boundary.
module track_step_ctrl #(
    parameter int WIDTH_IN  = 12,
    parameter int WIDTH_PER = 17,
    parameter int DEADZONE  = 9,
    parameter int PER_FAST  = 800,
    parameter int PER_MID   = 39600,
    parameter int PER_SLOW  = 80000,
    parameter int PULSE_W   = 50,
    parameter int DIR_SETUP = 250
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_valid,
    input  logic                 tr_mode_enable,
    input  logic [WIDTH_IN-1:0]  x,
    input  logic [WIDTH_IN-1:0]  x0,
    input  logic [WIDTH_IN-1:0]  dx1,
    input  logic [WIDTH_IN-1:0]  dx2,
    output logic                 drv_step,
    output logic                 drv_dir,
    output logic                 drv_enable_SM,
    output logic [WIDTH_PER-1:0] period,
    output logic [1:0]           state,
    output logic [15:0]          step_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIR_WAIT = 2'd1,
        S_STEPPING = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    localparam logic [WIDTH_PER-1:0] P_FAST       = WIDTH_PER'(PER_FAST);
    localparam logic [WIDTH_PER-1:0] P_MID        = WIDTH_PER'(PER_MID);
    localparam logic [WIDTH_PER-1:0] P_SLOW       = WIDTH_PER'(PER_SLOW);
    localparam logic [WIDTH_PER-1:0] P_PW         = WIDTH_PER'(PULSE_W);
    localparam logic [WIDTH_PER-1:0] P_SETUP_LAST = WIDTH_PER'(DIR_SETUP - 1);
    localparam logic [WIDTH_IN-1:0]  DZ           = WIDTH_IN'(DEADZONE);

    state_t                state_q, state_d;
    logic [WIDTH_IN-1:0]   xs_q, xs_d, x0s_q, x0s_d;
    logic [WIDTH_PER-1:0]  zone_q, zone_d;
    logic [WIDTH_PER-1:0]  period_q, period_d;
    logic [WIDTH_PER-1:0]  pcnt_q, pcnt_d;
    logic [WIDTH_PER-1:0]  setup_q, setup_d;
    logic                  dir_q, dir_d;
    logic                  step_q, step_d;
    logic                  en_q, en_d;
    logic [15:0]           sc_q, sc_d;
    logic [WIDTH_IN-1:0]   dx;
    logic                  dir_tgt;

    // Capture the sample pair on each strobe; everything downstream sees only these copies.
    always_comb begin
        xs_d  = xs_q;
        x0s_d = x0s_q;
        if (data_valid) begin
            xs_d  = x;
            x0s_d = x0;
        end
    end

    // Unsigned error magnitude and the direction that would reduce it.
    always_comb begin
        if (xs_q <= x0s_q) begin
            dx      = x0s_q - xs_q;
            dir_tgt = 1'b1;
        end else begin
            dx      = xs_q - x0s_q;
            dir_tgt = 1'b0;
        end
    end

    // Zone period from the error; zero error keeps whatever zone was last chosen.
    always_comb begin
        zone_d = zone_q;
        if (dx != '0) begin
            if (dx >= dx2)      zone_d = P_FAST;
            else if (dx >= dx1) zone_d = P_MID;
            else                zone_d = P_SLOW;
        end
    end

    // Next state, counters, direction and the registered motor outputs.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        setup_d  = setup_q;
        dir_d    = dir_q;
        period_d = period_q;
        case (state_q)
            S_IDLE: begin
                if (tr_mode_enable) begin
                    state_d = S_DIR_WAIT;
                    dir_d   = dir_tgt;
                    setup_d = '0;
                end
            end
            S_DIR_WAIT: begin
                if (!tr_mode_enable) begin
                    state_d = S_IDLE;
                end else if (setup_q >= P_SETUP_LAST) begin
                    state_d  = S_STEPPING;
                    pcnt_d   = '0;
                    period_d = zone_d;
                end else begin
                    setup_d = setup_q + 1'b1;
                end
            end
            S_STEPPING: begin
                // Disable waits for the pulse to finish so a step is never truncated.
                if (!tr_mode_enable && (pcnt_q >= P_PW)) begin
                    state_d = S_IDLE;
                end else if (pcnt_q >= period_q - 1'b1) begin
                    if (dx == '0) begin
                        state_d = S_HOLD;
                    end else if (dir_tgt != dir_q) begin
                        state_d = S_DIR_WAIT;
                        dir_d   = dir_tgt;
                        setup_d = '0;
                    end else begin
                        pcnt_d   = '0;
                        period_d = zone_d;
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!tr_mode_enable) begin
                    state_d = S_IDLE;
                end else if (dx >= DZ) begin
                    state_d = S_DIR_WAIT;
                    dir_d   = dir_tgt;
                    setup_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        step_d = (state_d == S_STEPPING) && (pcnt_d < P_PW);
        en_d   = (state_d == S_DIR_WAIT) || (state_d == S_STEPPING);
        sc_d   = sc_q;
        if (step_d && !step_q) begin
            sc_d = dir_q ? sc_q + 16'd1 : sc_q - 16'd1;
        end
    end

    // State register; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            xs_q     <= '0;
            x0s_q    <= '0;
            zone_q   <= P_SLOW;
            period_q <= P_SLOW;
            pcnt_q   <= '0;
            setup_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            en_q     <= 1'b0;
            sc_q     <= '0;
        end else begin
            state_q  <= state_d;
            xs_q     <= xs_d;
            x0s_q    <= x0s_d;
            zone_q   <= zone_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
            setup_q  <= setup_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            en_q     <= en_d;
            sc_q     <= sc_d;
        end
    end

    assign drv_step      = step_q;
    assign drv_dir       = dir_q;
    assign drv_enable_SM = en_q;
    assign period        = period_q;
    assign state         = state_q;
    assign step_count    = sc_q;

endmodule

// File: doc/track_step_ctrl.md
TRACK_STEP_CTRL -- requirements
Module: track_step_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 12: width of x, x0, dx1, dx2.
REQ-002 SHALL have parameter WIDTH_PER, default 17: width of step-period counter and period output.
REQ-003 SHALL have parameter DEADZONE, default 9: |dx| needed to leave HOLD.
REQ-004 SHALL have parameters PER_FAST=800, PER_MID=39600, PER_SLOW=80000: clk cycles per step in each zone; each SHALL be ≥ PULSE_W+1.
REQ-005 SHALL have parameter PULSE_W, default 50: drv_step high time in clk cycles.
REQ-006 SHALL have parameter DIR_SETUP, default 250: cycles drv_dir is held stable before the first step after any direction load.
REQ-007 SHALL have ports: clk  in  1  sole clock, 50 MHz; rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports: data_valid  in  1  ADC sample strobe, clk-synchronous, one cycle; tr_mode_enable  in  1  tracking enable.
REQ-009 SHALL have ports: x  in  WIDTH_IN  ADC value; x0  in  WIDTH_IN  table target; dx1  in  WIDTH_IN  slow/mid threshold; dx2  in  WIDTH_IN  mid/fast threshold.
REQ-010 SHALL have ports: drv_step  out  1  step pulse; drv_dir  out  1  direction; drv_enable_SM  out  1  motor enable.
REQ-011 SHALL have ports: period  out  WIDTH_PER  active step period; state  out  2  FSM state; step_count  out  16  signed net step position.

Function
REQ-012 SHALL register x and x0 on every clk where data_valid=1; all error math SHALL use registered copies xs, x0s only.
REQ-013 SHALL form dx = x0s−xs, dir_tgt=1 when xs≤x0s; else dx = xs−x0s, dir_tgt=0 (unsigned magnitude, no overflow).
REQ-014 SHALL select zone period by priority: dx≥dx2 → PER_FAST; dx≥dx1 → PER_MID; dx>0 → PER_SLOW; dx=0 → previous selection held.
REQ-015 SHALL make a new sample visible to dx/zone logic one clk after the data_valid cycle.
REQ-016 SHALL encode states IDLE=0, DIR_WAIT=1, STEPPING=2, HOLD=3 on output state.
REQ-017 IDLE: drv_enable_SM=0, drv_step=0; tr_mode_enable=1 → DIR_WAIT, drv_dir←dir_tgt, setup timer←0.
REQ-018 DIR_WAIT: drv_enable_SM=1, drv_step=0; after DIR_SETUP cycles → STEPPING, period counter←0, period←zone period; tr_mode_enable=0 → IDLE.
REQ-019 STEPPING: period counter counts 0..period−1 and wraps; drv_step=1 while counter<PULSE_W.
REQ-020 STEPPING: step_count SHALL change by +1 (drv_dir=1) or −1 (drv_dir=0) on the cycle drv_step rises; 16-bit two's-complement wrap, no saturation.
REQ-021 STEPPING: at counter=period−1, in priority: dx=0 → HOLD; dir_tgt≠drv_dir → DIR_WAIT with drv_dir←dir_tgt; else period←current zone period.
REQ-022 Zone changes mid-period SHALL take effect only at the next period boundary; a started pulse SHALL never be shortened.
REQ-023 STEPPING with tr_mode_enable=0: → IDLE on the first cycle where counter≥PULSE_W (immediately if already low).
REQ-024 HOLD: drv_enable_SM=0, drv_step=0; tr_mode_enable=0 → IDLE; else dx≥DEADZONE → DIR_WAIT with drv_dir←dir_tgt.
REQ-025 drv_dir SHALL change only on entry to DIR_WAIT; never while drv_step=1.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst=1 SHALL win over all other inputs on the same edge.
REQ-028 On rst: state=IDLE, drv_step=0, drv_dir=0, drv_enable_SM=0, step_count=0, period=PER_SLOW, xs=x0s=0, counters=0.
REQ-029 rst mid-pulse SHALL force drv_step=0 on the next cycle; no step_count update.

Verification
REQ-030 x0=1000, x=500, dx1=10, dx2=100, enable=1, one data_valid → state=1 for 250 cycles, drv_dir=1, then 50-high pulses every 800 cycles, step_count +1 each.
REQ-031 Same, then x=950 mid-period → current 800-cycle period completes, following periods 39600 cycles.
REQ-032 x crosses to 1004 during STEPPING → at period boundary drv_dir=0, 250 idle cycles, then step_count decrements.
REQ-033 x=x0 → HOLD, drv_enable_SM=0; x=x0+8 → stays HOLD; x=x0+9 → DIR_WAIT.
REQ-034 tr_mode_enable dropped at counter=10 → drv_step stays high to counter 49, then IDLE; rst asserted at counter=20 → drv_step=0 next cycle, all outputs at reset values.
REQ-035 32767 forward steps with PER_FAST=PULSE_W+1 → step_count wraps to −32768 on next step.
